// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit valid/ready words are shifted out one bit per clock.
// A one-entry holding register lets consecutive words stream with no idle gap.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             word_done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] sh_data;
  logic             hold_valid;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             load;

  // Bit that goes on the line next, and the word with that bit consumed.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign in_ready = !hold_valid && !clr;
  assign accept   = in_valid && in_ready;
  // A buffered word moves into the shifter when the line is idle or the current word ends.
  assign load     = hold_valid && ((state == IDLE) || (bit_cnt == LAST_IDX));

  // NOTE: hold_data and sh_data are never reset; hold_valid and the FSM gate every use of them.
  always_ff @(posedge clk) begin
    if (accept) hold_data <= in_data;
    if (load) sh_data <= advance(hold_data);
    else      sh_data <= advance(sh_data);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      hold_valid  <= 1'b0;
      bit_cnt     <= '0;
      ser_out     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      word_done   <= 1'b0;
    end else begin
      if (accept)    hold_valid <= 1'b1;
      else if (load) hold_valid <= 1'b0;

      // NOTE: non-blocking defaults here; a later assignment in the same edge overrides them.
      frame_start <= 1'b0;
      word_done   <= 1'b0;

      if (load) begin
        state       <= SHIFT;
        bit_cnt     <= '0;
        ser_out     <= head(hold_data);
        ser_valid   <= 1'b1;
        frame_start <= 1'b1;
      end else if ((state == SHIFT) && (bit_cnt != LAST_IDX)) begin
        bit_cnt   <= bit_cnt + 1'b1;
        ser_out   <= head(sh_data);
        ser_valid <= 1'b1;
        word_done <= (bit_cnt == LAST_IDX - 1'b1);
      end else begin
        state     <= IDLE;
        ser_out   <= IDLE_BIT;
        ser_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Randomized scoreboard bench for seq_serializer: an MSB-first and an LSB-first instance
// share one handshake stream and are checked bit-by-bit against a schedule-based model.
module tb_seq_serializer;

  localparam int W = 8;

  logic         clk;
  logic         clr;
  logic         in_valid;
  logic [W-1:0] in_data;

  logic in_ready_m, ser_out_m, ser_valid_m, frame_start_m, word_done_m;
  logic in_ready_l, ser_out_l, ser_valid_l, frame_start_l, word_done_l;

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
    .ser_out(ser_out_m), .ser_valid(ser_valid_m), .frame_start(frame_start_m),
    .word_done(word_done_m)
  );

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l), .frame_start(frame_start_l),
    .word_done(word_done_l)
  );

  // One expected line bit: the edge after which it must be visible, its value for each
  // bit order, and whether it opens or closes its word.
  typedef struct {
    int at_edge;
    bit msb;
    bit lsb;
    bit first;
    bit last;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cur_edge = 0;
  int last_end = 0;
  int pend_start = 0;
  bit hold_occ = 1'b0;
  bit accepted = 1'b0;
  bit mon_en = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at edge %0d", name, act, exp, cur_edge);
    end
  endtask

  // Advance one clock edge and update the reference model from the inputs present at it.
  // A word accepted at edge E starts at the later of E+1 and the edge after the previous
  // word's last bit, then occupies W consecutive edges; it sits in hold until its start.
  task automatic step();
    int start;
    logic [W-1:0] w;
    @(posedge clk);
    cur_edge++;
    accepted = 1'b0;
    if (clr) begin
      q.delete();
      hold_occ = 1'b0;
      last_end = cur_edge;
    end else if (hold_occ) begin
      if (pend_start == cur_edge) hold_occ = 1'b0;
    end else if (in_valid) begin
      w          = in_data;
      start      = (cur_edge + 1 > last_end + 1) ? cur_edge + 1 : last_end + 1;
      last_end   = start + W - 1;
      pend_start = start;
      hold_occ   = 1'b1;
      accepted   = 1'b1;
      for (int i = 0; i < W; i++)
        q.push_back('{at_edge: start + i, msb: w[W-1-i], lsb: w[i],
                      first: (i == 0), last: (i == W - 1)});
    end
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 64; i++) begin
      step();
      if (accepted) return;
    end
    check("send_accept", {31'd0, accepted}, 32'd1);
  endtask

  // Offer a fresh random value every cycle until one is taken.
  task automatic send_bp();
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = W'($urandom);
      step();
      if (accepted) return;
    end
    check("send_bp_accept", {31'd0, accepted}, 32'd1);
  endtask

  always @(negedge clk) begin : monitor
    bit   has_exp;
    exp_t e;
    if (mon_en) begin
      has_exp = (q.size() > 0) && (q[0].at_edge == cur_edge);
      check("in_ready_msb", {31'd0, in_ready_m}, {31'd0, !hold_occ && !clr});
      check("in_ready_lsb", {31'd0, in_ready_l}, {31'd0, !hold_occ && !clr});
      check("ser_valid_msb", {31'd0, ser_valid_m}, {31'd0, has_exp});
      check("ser_valid_lsb", {31'd0, ser_valid_l}, {31'd0, has_exp});
      if (has_exp) begin
        e = q.pop_front();
        check("ser_out_msb", {31'd0, ser_out_m}, {31'd0, e.msb});
        check("ser_out_lsb", {31'd0, ser_out_l}, {31'd0, e.lsb});
        check("frame_start_msb", {31'd0, frame_start_m}, {31'd0, e.first});
        check("frame_start_lsb", {31'd0, frame_start_l}, {31'd0, e.first});
        check("word_done_msb", {31'd0, word_done_m}, {31'd0, e.last});
        check("word_done_lsb", {31'd0, word_done_l}, {31'd0, e.last});
      end else begin
        check("idle_out_msb", {31'd0, ser_out_m}, 32'd0);
        check("idle_out_lsb", {31'd0, ser_out_l}, 32'd1);
        check("idle_pulses_msb", {30'd0, frame_start_m, word_done_m}, 32'd0);
        check("idle_pulses_lsb", {30'd0, frame_start_l, word_done_l}, 32'd0);
      end
    end
  end

  initial begin
    int dens;
    clr      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    step();
    mon_en = 1'b1;
    step();
    clr = 1'b0;
    idle(5);

    // Single words, both bit orders on the same handshake.
    send(8'hD0);
    idle(12);
    send(8'h0B);
    idle(12);

    // Back-to-back with in_valid held: second word waits for in_ready.
    send(8'hD0);
    send(8'hB4);
    idle(20);

    // Backpressure: hold full while shifting, in_data churning each cycle.
    send(8'h3C);
    send(8'hA5);
    send_bp();
    send_bp();
    idle(30);

    // Reset mid-word with a second word buffered, then a clean word afterwards.
    send(8'hE7);
    send(8'h5A);
    in_valid = 1'b0;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    idle(15);
    send(8'h96);
    idle(12);

    // Random traffic with varying density and occasional reset.
    for (int blk = 0; blk < 6; blk++) begin
      dens = $urandom_range(1, 4);
      for (int i = 0; i < 500; i++) begin
        clr      = ($urandom_range(0, 299) == 0);
        in_valid = ($urandom_range(0, 3) < dens);
        in_data  = W'($urandom);
        step();
      end
    end
    clr = 1'b0;
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
